serial_cmp_ctrl: RTL and testbench
==================================

SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a comparison; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  first operand, captured on the accepting edge.
REQ-006 SHALL have port: b  input  WIDTH  second operand, captured on the accepting edge.
REQ-007 SHALL have port: busy  output  1  high while in SHIFT or DONE.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have ports: gt, eq, lt  output  1 each  registered result, one-hot after first completion.

Function
REQ-010 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE; no other states reachable.
REQ-011 IDLE with start=1 at edge E0 SHALL load a, b into shift registers, clear bit counter, set compare state to EQ, enter SHIFT.
REQ-012 SHIFT SHALL process one bit pair per edge, LSB first, shifting both registers right by one.
REQ-013 Per bit: a_bit>b_bit sets state GT, a_bit<b_bit sets LT, equal bits leave state unchanged (higher bit overrides lower).
REQ-014 After exactly WIDTH SHIFT edges (edge E0+WIDTH) SHALL enter DONE and update gt/eq/lt from compare state.
REQ-015 done SHALL be 1 only for the single DONE cycle (between edges E0+WIDTH and E0+WIDTH+1); then IDLE.
REQ-016 gt/eq/lt SHALL hold their value until the next DONE entry; they do not change during SHIFT.
REQ-017 start while busy=1 SHALL be ignored; operands a, b are not re-sampled.
REQ-018 start held high SHALL launch a new comparison at the first IDLE edge after DONE (throughput one result per WIDTH+2 cycles).
REQ-019 Bit counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL not wrap within one operation.

Reset
REQ-020 reset=1 at any edge SHALL force IDLE, busy=0, done=0, gt=0, eq=0, lt=0, clear shift registers and counter.
REQ-021 reset SHALL take priority over start and over in-flight SHIFT/DONE; an aborted operation produces no done.

Configuration
REQ-022 Macro SERIAL_CMP_SIGNED_EN defined: operands SHALL be two's complement; on the final (MSB) bit a differing pair inverts sense (a_bit=1 -> LT, b_bit=1 -> GT).
REQ-023 Macro SERIAL_CMP_SIGNED_EN undefined: operands SHALL be unsigned; MSB treated as any other bit.

Structure
REQ-024 Package serial_cmp_pkg SHALL hold FSM state typedef (IDLE, SHIFT, DONE) and 2-bit result encoding CMP_EQ, CMP_GT, CMP_LT.
REQ-025 Per-bit compare state flop SHALL be sub-module serial_cmp_cell (inputs a_bit, b_bit, clear, en, last; output 2-bit state), instantiated once.

Verification (WIDTH=8)
REQ-026 a=8'h5A, b=8'h5A, start at E0 -> done=1 only in cycle after E8, eq=1, gt=lt=0, busy=0 after E9.
REQ-027 a=8'h80, b=8'h7F -> gt=1 unsigned; with SERIAL_CMP_SIGNED_EN -> lt=1.
REQ-028 a=8'h01, b=8'h02 -> lt=1 (bit1 overrides bit0 difference).
REQ-029 start with a=8'h10,b=8'h20 at E0, then start with a=8'hFF,b=8'h00 at E3 -> ignored; result lt=1, single done pulse.
REQ-030 reset=1 at E4 of a SHIFT -> after E4 busy=0, done=0, gt=eq=lt=0, no done follows; next start a=8'h03,b=8'h03 yields eq=1 after 8 shifts.
REQ-031 start held high with a=8'h01,b=8'h00 -> done pulses every 10 cycles, gt=1 each time.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg -- shared types and helpers for the bit-serial comparator.
//   state_t   : controller FSM states (IDLE, SHIFT, DONE)
//   CMP_*     : 2-bit running compare-result encoding
//   cmp_step  : one LSB-first compare step (used by the cell and the top)
// Optional feature: define SERIAL_CMP_SIGNED_EN for two's complement operands.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // Bits are consumed LSB first, so any differing pair overrides whatever
  // the lower bits decided. In signed mode the sign bit carries negative
  // weight, which flips the sense of a difference on the last bit.
  function automatic logic [1:0] cmp_step(input logic [1:0] cur,
                                          input logic       a_bit,
                                          input logic       b_bit,
                                          input logic       last);
    logic [1:0] nxt;
    nxt = cur;
    if (a_bit != b_bit) begin
`ifdef SERIAL_CMP_SIGNED_EN
      if (last) begin
        nxt = a_bit ? CMP_LT : CMP_GT;
      end else begin
        nxt = a_bit ? CMP_GT : CMP_LT;
      end
`else
      if (last) begin
        nxt = a_bit ? CMP_GT : CMP_LT;
      end else begin
        nxt = a_bit ? CMP_GT : CMP_LT;
      end
`endif
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/serial_cmp_cell.sv
// serial_cmp_cell -- running compare-state flop for the bit-serial comparator.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   a_bit,b_bit: current bit pair
//   clear      : restart at CMP_EQ (operation start)
//   en         : fold the current bit pair into the state
//   last       : current pair is the MSB (matters when SERIAL_CMP_SIGNED_EN)
//   state      : registered running result (CMP_EQ/CMP_GT/CMP_LT)
module serial_cmp_cell
  import serial_cmp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic       clear,
  input  logic       en,
  input  logic       last,
  output logic [1:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CMP_EQ;
    end else if (clear) begin
      state <= CMP_EQ;
    end else if (en) begin
      state <= cmp_step(state, a_bit, b_bit, last);
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl -- bit-serial magnitude comparator, one bit per clock.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : request a comparison (accepted only in IDLE)
//   a, b        : WIDTH-bit operands, captured on the accepting edge
//   busy        : high during SHIFT and DONE
//   done        : one-cycle pulse when gt/eq/lt are updated
//   gt, eq, lt  : registered result, held until the next completion
// Macro SERIAL_CMP_SIGNED_EN selects two's complement operands
// (default: unsigned).
module serial_cmp_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             shift_en;
  logic             last_bit;
  logic [1:0]       cmp_state;
  logic [1:0]       final_res;

  assign last_bit = (cnt == LAST_CNT);

  // The cell's state is one edge behind the bit being shifted on the last
  // SHIFT edge, so fold that final pair in here to publish on DONE entry.
  assign final_res = cmp_step(cmp_state, a_sh[0], b_sh[0], last_bit);

  serial_cmp_cell u_cell (
    .clk   (clk),
    .reset (reset),
    .a_bit (a_sh[0]),
    .b_bit (b_sh[0]),
    .clear (load),
    .en    (shift_en),
    .last  (last_bit),
    .state (cmp_state)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
      if (load) begin
        a_sh <= a;
        b_sh <= b;
        cnt  <= '0;
      end else if (shift_en) begin
        a_sh <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh <= {1'b0, b_sh[WIDTH-1:1]};
        cnt  <= cnt + CW'(1);
      end else begin
        a_sh <= a_sh;
        b_sh <= b_sh;
        cnt  <= cnt;
      end
      if (shift_en && last_bit) begin
        gt <= (final_res == CMP_GT);
        eq <= (final_res == CMP_EQ);
        lt <= (final_res == CMP_LT);
      end else begin
        gt <= gt;
        eq <= eq;
        lt <= lt;
      end
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// tb_serial_cmp_ctrl -- scoreboard bench for serial_cmp_ctrl (WIDTH=8).
// Expected {gt,eq,lt} are pushed when an operation is launched and popped
// by a monitor whenever done pulses.
module tb_serial_cmp_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  int         checks;
  int         failures;
  logic [2:0] exp_q[$];
  logic [2:0] last_res;

  serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .eq    (eq),
    .lt    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference result as {gt,eq,lt}.
  function automatic logic [2:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SERIAL_CMP_SIGNED_EN
    if ($signed(x) > $signed(y)) return 3'b100;
    else if ($signed(x) < $signed(y)) return 3'b001;
    else return 3'b010;
`else
    if (x > y) return 3'b100;
    else if (x < y) return 3'b001;
    else return 3'b010;
`endif
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        check_val("result", {29'd0, gt, eq, lt}, {29'd0, e});
      end
    end
  end

  // Launch one comparison and check cycle-exact timing around it.
  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input string tag);
    logic [2:0] e;
    e = model(x, y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);                  // after E0
    start = 1'b0;
    check_val({tag, "_busy_shift"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i < WIDTH; i++) begin
      @(negedge clk);                // after Ei
      check_val({tag, "_done_early"}, {31'd0, done}, 32'd0);
      check_val({tag, "_hold"}, {29'd0, gt, eq, lt}, {29'd0, last_res});
    end
    @(negedge clk);                  // after E8
    check_val({tag, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk);                  // after E9
    check_val({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    check_val({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
    last_res = e;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_timeout"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    last_res = 3'b000;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_res", {29'd0, gt, eq, lt}, 32'd0);
    reset = 1'b0;

    do_op(8'h5A, 8'h5A, "eq5a");
    do_op(8'h80, 8'h7F, "msb");
    do_op(8'h01, 8'h02, "bit1");
    do_op(8'hFF, 8'hFE, "lsb");
    do_op(8'h00, 8'hFF, "zero_ff");
    for (int k = 0; k < 6; k++) begin
      do_op(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), "rnd");
    end

    // Start while busy is ignored; operands are not re-sampled.
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20));
    @(negedge clk); start = 1'b0;    // after E0
    @(negedge clk);                  // after E1
    @(negedge clk);                  // after E2
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;    // after E3
    wait_done(20, "busy_start");
    check_val("busy_start_lt", {31'd0, lt}, 32'd1);
    repeat (12) @(negedge clk);      // monitor flags any second done
    last_res = {gt, eq, lt};

    // Reset mid-SHIFT aborts the operation with no done.
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;    // after E0
    @(negedge clk);                  // after E1
    @(negedge clk);                  // after E2
    @(negedge clk);                  // after E3
    reset = 1'b1;
    @(negedge clk);                  // after E4
    reset = 1'b0;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    check_val("abort_res", {29'd0, gt, eq, lt}, 32'd0);
    repeat (12) @(negedge clk);
    last_res = 3'b000;
    do_op(8'h03, 8'h03, "post_abort");

    // Start held high: one result every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h01; b = 8'h00; start = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(model(8'h01, 8'h00));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);                // after Ei
      if (i == 20) start = 1'b0;
      check_val("hold_done", {31'd0, done}, {31'd0, (i == 8 || i == 18 || i == 28)});
    end
    check_val("hold_gt", {31'd0, gt}, 32'd1);
    repeat (4) @(negedge clk);
    check_val("hold_idle", {31'd0, busy}, 32'd0);
    check_val("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
